// File: rtl/spike_event_queue.sv
// -----------------------------------------------------------------------------
// spike_event_queue
//
// Purpose:
//   Wishbone-mapped spike input queue in front of the neuron core. The
//   management SoC pushes 8-bit axon indices into a FIFO. The FIFO head is
//   offered to the core over a valid/ready handshake. A timestep tick is
//   requested over the bus and released as a one-cycle pulse, but only once
//   every queued spike has been consumed.
//
// Ports:
//   clk, rst              - single clock, synchronous active-high reset
//   wbs_cyc_i, wbs_stb_i  - Wishbone cycle / strobe
//   wbs_we_i              - Wishbone write enable
//   wbs_sel_i             - byte selects (ignored, full-word access only)
//   wbs_adr_i, wbs_dat_i  - byte address / write data
//   wbs_ack_o, wbs_dat_o  - one-cycle acknowledge / registered read data
//   spike_valid_o         - FIFO head is valid
//   spike_axon_o          - axon index at the FIFO head
//   spike_ready_i         - neuron core accepts the head entry
//   tick_o                - one-cycle timestep pulse
//
// Register map (offset from ADDR_BASE):
//   0x00 PUSH (W)    dat[7:0] pushed into the FIFO
//   0x04 STATUS (R)  [6:0] count, [8] full, [9] empty, [10] tick_pending,
//                    [16] overflow (sticky)
//   0x08 TICK (W)    dat[0]=1 requests a tick
//   0x0C CLEAR (W)   dat[0]=1 flushes FIFO, overflow and tick_pending
//   0x10 STATS       dispatched-spike counter (optional)
//   0x14-0x1C        reserved, read as 0
//
// Optional build macro:
//   SPIKE_QUEUE_STATS_EN - when defined, 0x10 reads a 32-bit pop counter;
//                          any write to 0x10 (or a CLEAR) zeroes it. When
//                          undefined, 0x10 reads 0 and writes are ignored.
// -----------------------------------------------------------------------------
module spike_event_queue #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        spike_valid_o,
   output logic [7:0]  spike_axon_o,
   input  logic        spike_ready_i,
   output logic        tick_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FIRE  = 2'd2
   } tick_state_t;

   // ---------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------
   logic [7:0]    r_mem [DEPTH];
   logic [7:0]    r_head;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          r_pend;
   logic          r_ack;
   logic [31:0]   r_dat;
   tick_state_t   r_state;

   tick_state_t   w_state_next;
   logic [CW-1:0] w_count_next;
   logic [AW-1:0] w_rptr_next;
   logic [31:0]   w_rd_data;
   logic [31:0]   w_status;
   logic [31:0]   w_stats;

   // ---------------------------------------------------------------------
   // Wishbone decode. The "!r_ack" term forces a dead cycle between
   // back-to-back requests so each access gets exactly one ack pulse.
   // ---------------------------------------------------------------------
   logic       w_decode;
   logic       w_req;
   logic [2:0] w_off;
   logic       w_wr;
   logic       w_rd;
   logic       w_push;
   logic       w_tick_wr;
   logic       w_clear;
   logic       w_stats_wr;

   assign w_decode   = (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
   assign w_req      = wbs_cyc_i && wbs_stb_i && !r_ack && w_decode;
   assign w_off      = wbs_adr_i[4:2];
   assign w_wr       = w_req && wbs_we_i;
   assign w_rd       = w_req && !wbs_we_i;
   assign w_push     = w_wr && (w_off == 3'd0);
   assign w_tick_wr  = w_wr && (w_off == 3'd2) && wbs_dat_i[0];
   assign w_clear    = w_wr && (w_off == 3'd3) && wbs_dat_i[0];
   assign w_stats_wr = w_wr && (w_off == 3'd4);

   // ---------------------------------------------------------------------
   // FIFO control. Fullness is judged on the count before any same-cycle
   // pop, so a push into a full FIFO is always dropped. CLEAR wins over pop.
   // ---------------------------------------------------------------------
   logic w_full;
   logic w_empty;
   logic w_push_ok;
   logic w_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_push_ok = w_push && !w_full;
   assign w_pop     = !w_empty && spike_ready_i;

   always_comb begin
      w_count_next = r_count;
      w_rptr_next  = r_rptr;
      if (w_clear) begin
         w_count_next = '0;
         w_rptr_next  = '0;
      end else begin
         w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop);
         w_rptr_next  = r_rptr + AW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= wbs_dat_i[7:0];
      end
   end

   // Registered head read addressed by the next read pointer. When the
   // entry being written this edge becomes the head (FIFO empty after the
   // pop), the write data is forwarded instead of the stale array word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= 8'd0;
      end else if (w_push_ok && (r_wptr == w_rptr_next)) begin
         r_head <= wbs_dat_i[7:0];
      end else begin
         r_head <= r_mem[w_rptr_next];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_rptr  <= w_rptr_next;
         r_count <= w_count_next;
         if (w_clear) begin
            r_wptr <= '0;
            r_ovf  <= 1'b0;
         end else begin
            if (w_push_ok) begin
               r_wptr <= r_wptr + AW'(1);
            end
            if (w_push && w_full) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign spike_valid_o = !w_empty;
   assign spike_axon_o  = w_empty ? 8'd0 : r_head;

   // ---------------------------------------------------------------------
   // Tick sequencer. DRAIN looks at the post-edge count so the pulse lands
   // on the cycle right after the edge that empties the FIFO. IDLE also
   // reacts to the TICK write itself, giving N+2 latency into an empty FIFO.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      tick_o       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_pend || w_tick_wr) && !w_clear) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_clear) begin
               w_state_next = S_IDLE;
            end else if (w_count_next == '0) begin
               w_state_next = S_FIRE;
            end
         end
         S_FIRE: begin
            tick_o       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Only one request can be outstanding: extra TICK writes while draining
   // just re-set an already-set flag, and FIRE clears it unconditionally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= 1'b0;
      end else if (w_clear || (r_state == S_FIRE)) begin
         r_pend <= 1'b0;
      end else if (w_tick_wr) begin
         r_pend <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Optional dispatched-spike counter
   // ---------------------------------------------------------------------
`ifdef SPIKE_QUEUE_STATS_EN
   logic [31:0] r_pop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pop_cnt <= 32'd0;
      end else if (w_clear || w_stats_wr) begin
         r_pop_cnt <= 32'd0;
      end else if (w_pop) begin
         r_pop_cnt <= r_pop_cnt + 32'd1;
      end
   end

   assign w_stats = r_pop_cnt;

   logic w_unused;
   assign w_unused = ^{wbs_sel_i, wbs_dat_i[31:8], wbs_adr_i[1:0]};
`else
   assign w_stats = 32'd0;

   logic w_unused;
   assign w_unused = ^{wbs_sel_i, wbs_dat_i[31:8], wbs_adr_i[1:0], w_stats_wr};
`endif

   // ---------------------------------------------------------------------
   // Read mux and registered bus response
   // ---------------------------------------------------------------------
   always_comb begin
      w_status      = 32'd0;
      w_status[6:0] = 7'(r_count);
      w_status[8]   = w_full;
      w_status[9]   = w_empty;
      w_status[10]  = r_pend;
      w_status[16]  = r_ovf;
   end

   always_comb begin
      w_rd_data = 32'd0;
      case (w_off)
         3'd1:    w_rd_data = w_status;
         3'd4:    w_rd_data = w_stats;
         default: w_rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack <= 1'b0;
         r_dat <= 32'd0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_rd ? w_rd_data : 32'd0;
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_spike_event_queue.sv
// -----------------------------------------------------------------------------
// tb_spike_event_queue
//
// Self-checking bench for spike_event_queue. A behavioural model (a byte
// queue plus a few flags) predicts the bus response, FIFO head and tick
// pulse every cycle. Directed sequences follow the test plan, then a long
// randomized phase mixes bus traffic, back-pressure and resets.
// Honours SPIKE_QUEUE_STATS_EN in the model the same way as the design.
// -----------------------------------------------------------------------------
module tb_spike_event_queue;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic        clk;
   logic        rst;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        spike_valid_o;
   logic [7:0]  spike_axon_o;
   logic        spike_ready_i;
   logic        tick_o;

   spike_event_queue #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
      .clk           (clk),
      .rst           (rst),
      .wbs_cyc_i     (wbs_cyc_i),
      .wbs_stb_i     (wbs_stb_i),
      .wbs_we_i      (wbs_we_i),
      .wbs_sel_i     (wbs_sel_i),
      .wbs_adr_i     (wbs_adr_i),
      .wbs_dat_i     (wbs_dat_i),
      .wbs_ack_o     (wbs_ack_o),
      .wbs_dat_o     (wbs_dat_o),
      .spike_valid_o (spike_valid_o),
      .spike_axon_o  (spike_axon_o),
      .spike_ready_i (spike_ready_i),
      .tick_o        (tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=0x%08h exp=0x%08h", tag, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [7:0]  m_q[$];
   bit        m_ovf, m_pend, m_armed, m_fire, m_ack;
   bit [31:0] m_dat, m_stats;

   bit        chk_en = 0;
   logic [31:0] obs_dat;
   logic [7:0]  obs_axon;
   logic        obs_valid;
   int          tick_seen = 0;

   task automatic model_step();
      bit        req, pop, clr, push, tw, sw, we;
      bit [2:0]  off;
      bit [31:0] rd;
      int        sz;
      if (rst) begin
         m_q.delete();
         m_ovf = 0; m_pend = 0; m_armed = 0; m_fire = 0;
         m_ack = 0; m_dat = 0; m_stats = 0;
         return;
      end
      sz   = m_q.size();
      req  = wbs_cyc_i && wbs_stb_i && !m_ack && ((wbs_adr_i >> 5) == (BASE >> 5));
      off  = wbs_adr_i[4:2];
      we   = wbs_we_i;
      pop  = (sz > 0) && spike_ready_i;
      clr  = req && we && off == 3 && wbs_dat_i[0];
      push = req && we && off == 0;
      tw   = req && we && off == 2 && wbs_dat_i[0];
      sw   = req && we && off == 4;
      rd = 0;
      if (off == 1)
         rd = sz | ((sz == DEPTH) << 8) | ((sz == 0) << 9) | (32'(m_pend) << 10) | (32'(m_ovf) << 16);
`ifdef SPIKE_QUEUE_STATS_EN
      if (off == 4) rd = m_stats;
`endif
      if (req)
         $display("txn t=%0t %s off=0x%02h wdat=0x%08h rdat=0x%08h", $time,
                  we ? "WR" : "RD", 32'(off) * 4, wbs_dat_i, we ? 32'd0 : rd);
      m_ack = req;
      m_dat = (req && !we) ? rd : 32'd0;
      // FIFO contents
      if (clr) begin
         m_q.delete();
         m_ovf = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (sz == DEPTH) m_ovf = 1;
            else m_q.push_back(wbs_dat_i[7:0]);
         end
      end
      // dispatched count
      if (clr || sw) m_stats = 0;
      else if (pop) m_stats = m_stats + 1;
      // tick: fires the cycle after the FIFO is seen empty while armed
      if (m_fire) begin
         m_fire = 0;
         m_pend = 0;
      end else if (m_armed) begin
         if (clr) begin
            m_armed = 0;
            m_pend  = 0;
         end else if (m_q.size() == 0) begin
            m_armed = 0;
            m_fire  = 1;
         end
      end else begin
         if (clr) m_pend = 0;
         else if (tw || m_pend) begin
            m_pend  = 1;
            m_armed = 1;
         end
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance model over the edge.
   task automatic cycle();
      bit [7:0] head;
      @(negedge clk);
      head = 8'd0;
      if (m_q.size() > 0) head = m_q[0];
      if (chk_en) begin
         check_val("ack",   32'(wbs_ack_o),     32'(m_ack));
         check_val("rdat",  wbs_dat_o,          m_dat);
         check_val("valid", 32'(spike_valid_o), 32'(m_q.size() > 0));
         check_val("axon",  32'(spike_axon_o),  32'(head));
         check_val("tick",  32'(tick_o),        32'(m_fire));
      end
      obs_dat   = wbs_dat_o;
      obs_axon  = spike_axon_o;
      obs_valid = spike_valid_o;
      if (tick_o) tick_seen++;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Single bus access; obs_dat holds the ack-cycle data afterwards.
   task automatic wb_op(input bit we, input logic [31:0] off, input logic [31:0] d);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
      wbs_adr_i = BASE + off; wbs_dat_i = d;
      cycle();
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      cycle();
   endtask

   localparam logic [31:0] STATS_EXP7 =
`ifdef SPIKE_QUEUE_STATS_EN
      32'd7;
`else
      32'd0;
`endif

   int ready_pct;
   int r;

   initial begin
      bit [7:0] seq [3];
      rst = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      wbs_sel_i = 4'hF; wbs_adr_i = 0; wbs_dat_i = 0; spike_ready_i = 0;
      @(posedge clk); #1;
      cycle();
      chk_en = 1;
      cycle();
      rst = 0;
      idle(2);

      // reset state
      wb_op(0, 32'h04, 0);
      check_val("status_reset", obs_dat, 32'h0000_0200);

      // three pushes, then drain with ready high
      seq[0] = 8'h05; seq[1] = 8'hA3; seq[2] = 8'hFF;
      for (int i = 0; i < 3; i++) wb_op(1, 32'h00, 32'(seq[i]));
      wb_op(0, 32'h04, 0);
      check_val("status_count3", obs_dat, 32'h0000_0003);
      spike_ready_i = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_val("head_seq", 32'(obs_axon), 32'(seq[i]));
      end
      cycle();
      check_val("valid_after_drain", 32'(obs_valid), 32'd0);
      spike_ready_i = 0;

      // overflow then CLEAR
      for (int i = 0; i < DEPTH + 1; i++) wb_op(1, 32'h00, 32'(i * 7));
      wb_op(0, 32'h04, 0);
      check_val("status_full_ovf", obs_dat, 32'h0001_0110);
      wb_op(1, 32'h0C, 1);
      wb_op(0, 32'h04, 0);
      check_val("status_after_clear", obs_dat, 32'h0000_0200);

      // tick held off by back-pressure
      for (int i = 0; i < 4; i++) wb_op(1, 32'h00, 32'(8'h40 + i));
      tick_seen = 0;
      wb_op(1, 32'h08, 1);
      idle(10);
      check_val("tick_held", 32'(tick_seen), 32'd0);
      spike_ready_i = 1;
      idle(10);
      check_val("tick_once", 32'(tick_seen), 32'd1);
      wb_op(0, 32'h04, 0);
      check_val("pending_cleared", obs_dat, 32'h0000_0200);

      // double TICK while draining -> one pulse
      spike_ready_i = 0;
      for (int i = 0; i < 3; i++) wb_op(1, 32'h00, 32'(i + 1));
      tick_seen = 0;
      wb_op(1, 32'h08, 1);
      wb_op(1, 32'h08, 1);
      spike_ready_i = 1;
      idle(10);
      check_val("tick_absorbed", 32'(tick_seen), 32'd1);

      // reset mid-drain
      spike_ready_i = 0;
      for (int i = 0; i < 3; i++) wb_op(1, 32'h00, 32'(i + 9));
      wb_op(1, 32'h08, 1);
      idle(3);
      tick_seen = 0;
      rst = 1;
      cycle();
      rst = 0;
      spike_ready_i = 1;
      idle(10);
      check_val("tick_after_rst", 32'(tick_seen), 32'd0);
      wb_op(0, 32'h04, 0);
      check_val("status_after_rst", obs_dat, 32'h0000_0200);

      // dispatched-spike counter
      spike_ready_i = 0;
      wb_op(1, 32'h10, 0);
      for (int i = 0; i < 7; i++) wb_op(1, 32'h00, 32'(i));
      spike_ready_i = 1;
      idle(10);
      wb_op(0, 32'h10, 0);
      check_val("stats7", obs_dat, STATS_EXP7);
      wb_op(1, 32'h10, 32'hDEAD_BEEF);
      wb_op(0, 32'h10, 0);
      check_val("stats_zeroed", obs_dat, 32'd0);

      // randomized traffic
      ready_pct = 50;
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) ready_pct = $urandom_range(0, 100);
         rst = ($urandom_range(0, 299) == 0);
         spike_ready_i = ($urandom_range(0, 99) < ready_pct);
         if ($urandom_range(0, 99) < 45) begin
            wbs_cyc_i = 1; wbs_stb_i = 1;
            wbs_dat_i = $urandom;
            r = $urandom_range(0, 99);
            if (r < 40) begin
               wbs_adr_i = BASE; wbs_we_i = 1;
            end else if (r < 55) begin
               wbs_adr_i = BASE + 32'h04; wbs_we_i = ($urandom_range(0, 9) == 0);
            end else if (r < 65) begin
               wbs_adr_i = BASE + 32'h08; wbs_we_i = 1;
            end else if (r < 70) begin
               wbs_adr_i = BASE + 32'h0C; wbs_we_i = 1;
               wbs_dat_i[0] = ($urandom_range(0, 3) == 0);
            end else if (r < 76) begin
               wbs_adr_i = BASE + 32'h10; wbs_we_i = $urandom_range(0, 1);
            end else if (r < 82) begin
               wbs_adr_i = BASE + 32'h14 + 32'($urandom_range(0, 2)) * 4;
               wbs_we_i = $urandom_range(0, 1);
            end else begin
               wbs_adr_i = ($urandom_range(0, 1) == 0) ? (BASE + 32'h20) : 32'h2000_0004;
               wbs_we_i = $urandom_range(0, 1);
            end
         end else begin
            wbs_cyc_i = $urandom_range(0, 1);
            wbs_stb_i = 0;
            wbs_we_i  = 0;
         end
         cycle();
      end
      rst = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
